// File: rtl/adder_multiword_seq_pkg.sv
// Shared types for the multiword add/sub sequencer.
// Prefix-carry cells and FSM encodings.
package adder_multiword_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } adder_seq_state_t;

  typedef enum logic {
    OP_ADD,
    OP_SUB
  } adder_op_t;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Combine a high group with the adjacent low group.
  function automatic pg_t lkpg(
    input pg_t hi,
    input pg_t lo
  );
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

  // Counter width for n chunks, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_multiword_seq_chain.sv
// Kogge-Stone prefix network, purely combinational.
// c[i] is the group generate of bits i..0.
module carry_chain_kogge_stone
  import adder_multiword_seq_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  output logic [W-1:0] c
);

  localparam int L = (W > 1) ? $clog2(W) : 1;

  pg_t st [L+1][W];

  for (genvar i = 0; i < W; i++) begin : g_in
    assign st[0][i] = pg_t'{p: p[i], g: g[i]};
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign st[l+1][i] =
          lkpg(st[l][i], st[l][i-(1<<l)]);
      end else begin : g_pass
        assign st[l+1][i] = st[l][i];
      end
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_out
    assign c[i] = st[L][i].g;
  end

endmodule

// File: rtl/adder_multiword_seq.sv
// Wide add/subtract done one W-bit chunk per cycle.
// Single shared carry chain, carry held in a register.
module adder_multiword_seq
  import adder_multiword_seq_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  input  logic         in_op,
  input  logic         in_cin,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [N*W-1:0] out_y,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int NW = N * W;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  adder_seq_state_t state_q, state_d;
  adder_op_t        op;

  logic [NW-1:0] a_q, b_q, y_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, cout_q, ovf_q;

  logic          acc, step, fin;
  logic [W-1:0]  a_k, b_k, p_k, g_k, sum_k;
  logic [W:0]    cc;
  logic          ovf_k;

  assign op = adder_op_t'(in_op);

  assign a_k = a_q[cnt_q*W +: W];
  assign b_k = b_q[cnt_q*W +: W];
  assign p_k = a_k ^ b_k;
  assign g_k = a_k & b_k;

  carry_chain_kogge_stone #(
    .W(W + 1)
  ) u_chain (
    .p({p_k, 1'b0}),
    .g({g_k, carry_q}),
    .c(cc)
  );

  assign sum_k = p_k ^ cc[W-1:0];
  assign ovf_k = (a_q[NW-1] == b_q[NW-1])
               & (sum_k[W-1] != a_q[NW-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs from state alone.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    acc     = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          acc     = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (acc) begin
        a_q     <= in_a;
        b_q     <= (op == OP_SUB) ? ~in_b : in_b;
        carry_q <= (op == OP_SUB) ? 1'b1 : in_cin;
        cnt_q   <= '0;
      end
      if (step) begin
        y_q[cnt_q*W +: W] <= sum_k;
        carry_q <= cc[W];
        cnt_q   <= fin ? '0 : cnt_q + 1'b1;
        if (fin) begin
          cout_q <= cc[W];
          ovf_q  <= ovf_k;
        end
      end
    end
  end

  assign out_y    = y_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_adder_multiword_seq.sv
// Random and directed checks of the multiword sequencer
// against a plain wide-arithmetic model.
module tb_adder_multiword_seq;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NW = N * W;

  typedef logic [NW:0] chk_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic          in_rdy;
  logic [NW-1:0] in_a, in_b;
  logic          in_op, in_cin;
  logic          out_vld;
  logic          out_rdy;
  logic [NW-1:0] out_y;
  logic          out_cout, out_ovf;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  adder_multiword_seq #(
    .W(W),
    .N(N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_op   (in_op),
    .in_cin  (in_cin),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_y   (out_y),
    .out_cout(out_cout),
    .out_ovf (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string tag,
    input chk_t  got,
    input chk_t  exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [NW-1:0] a,
    input  logic [NW-1:0] b,
    input  logic          op,
    input  logic          cin,
    output logic [NW-1:0] y,
    output logic          co,
    output logic          ov
  );
    logic [NW:0] s;
    if (!op) begin
      s  = {1'b0, a} + {1'b0, b} + chk_t'(cin);
      co = s[NW];
      ov = (a[NW-1] == b[NW-1]) && (s[NW-1] != a[NW-1]);
    end else begin
      s  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
      ov = (a[NW-1] != b[NW-1]) && (s[NW-1] != a[NW-1]);
    end
    y = s[NW-1:0];
  endfunction

  function automatic logic [NW-1:0] rnd_opnd();
    logic [NW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 5))
        0: v[k*W +: W] = '0;
        1: v[k*W +: W] = '1;
        2: v[k*W +: W] = 32'h8000_0000;
        3: v[k*W +: W] = 32'h7fff_ffff;
        default: v[k*W +: W] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic run_op(
    input logic [NW-1:0] a,
    input logic [NW-1:0] b,
    input logic          op,
    input logic          cin,
    input logic [NW-1:0] ey,
    input logic          ec,
    input logic          eo,
    input int            gap,
    input int            rdy_pct
  );
    int  t0, n;
    logic hold;
    in_vld = 1'b0;
    repeat (gap) begin
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end
    in_a   = a;
    in_b   = b;
    in_op  = op;
    in_cin = cin;
    in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 64) begin
      tick();
      n++;
    end
    check("acc_rdy", chk_t'(in_rdy), chk_t'(1));
    t0 = cyc;
    tick();
    in_vld = 1'b0;
    in_a   = $urandom;
    in_b   = ~a;
    in_op  = ~op;
    in_cin = ~cin;
    n = 0;
    while (!out_vld && n < 64) begin
      check("busy_rdy", chk_t'(in_rdy), chk_t'(0));
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      tick();
      n++;
    end
    check("latency", chk_t'(cyc - t0), chk_t'(N + 1));
    check("y", chk_t'(out_y), chk_t'(ey));
    check("cout", chk_t'(out_cout), chk_t'(ec));
    check("ovf", chk_t'(out_ovf), chk_t'(eo));
    n = 0;
    while (out_vld) begin
      out_rdy = ($urandom_range(0, 99) < rdy_pct)
              || (n >= 100);
      hold = out_rdy;
      tick();
      n++;
      if (hold) begin
        check("vld_drop", chk_t'(out_vld), chk_t'(0));
        check("rdy_back", chk_t'(in_rdy), chk_t'(1));
        break;
      end
      check("hold_vld", chk_t'(out_vld), chk_t'(1));
      check("hold_y", chk_t'(out_y), chk_t'(ey));
      check("hold_rdy", chk_t'(in_rdy), chk_t'(0));
    end
    out_rdy = 1'b0;
  endtask

  logic [NW-1:0] ones, msb, y_m;
  logic          c_m, o_m;
  int            n;

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_op   = 1'b0;
    in_cin  = 1'b0;
    out_rdy = 1'b0;
    ones    = '1;
    msb     = '0;
    msb[NW-1] = 1'b1;
    repeat (3) tick();
    check("rst_in_rdy", chk_t'(in_rdy), chk_t'(1));
    check("rst_out_vld", chk_t'(out_vld), chk_t'(0));
    check("rst_y", chk_t'(out_y), chk_t'(0));
    check("rst_cout", chk_t'(out_cout), chk_t'(0));
    check("rst_ovf", chk_t'(out_ovf), chk_t'(0));
    rst_n = 1'b1;
    tick();

    run_op(ones, 1, 0, 0, '0, 1, 0, 0, 100);
    run_op('0, 1, 1, 0, ones, 0, 0, 0, 100);
    run_op(msb, 1, 1, 0, ~msb, 1, 1, 0, 100);
    run_op(~msb, 1, 0, 0, msb, 0, 1, 0, 100);
    run_op('0, '0, 0, 1, 1, 0, 0, 1, 100);

    in_a    = 5;
    in_b    = 7;
    in_op   = 1'b0;
    in_cin  = 1'b0;
    in_vld  = 1'b1;
    out_rdy = 1'b0;
    tick();
    in_a  = 100;
    in_b  = 1;
    in_op = 1'b1;
    n = 0;
    while (!out_vld && n < 32) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_vld", chk_t'(out_vld), chk_t'(1));
      check("bp_y", chk_t'(out_y), chk_t'(12));
      check("bp_in_rdy", chk_t'(in_rdy), chk_t'(0));
      tick();
    end
    out_rdy = 1'b1;
    tick();
    check("bp_release_vld", chk_t'(out_vld), chk_t'(0));
    check("bp_release_rdy", chk_t'(in_rdy), chk_t'(1));
    tick();
    in_vld = 1'b0;
    check("bp_second_acc", chk_t'(in_rdy), chk_t'(0));
    n = 0;
    while (!out_vld && n < 32) begin
      tick();
      n++;
    end
    check("bp_second_y", chk_t'(out_y), chk_t'(99));
    check("bp_second_cout", chk_t'(out_cout), chk_t'(1));
    tick();
    out_rdy = 1'b0;

    in_a   = ones;
    in_b   = ones;
    in_op  = 1'b0;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_rdy", chk_t'(in_rdy), chk_t'(1));
    check("mid_rst_vld", chk_t'(out_vld), chk_t'(0));
    check("mid_rst_y", chk_t'(out_y), chk_t'(0));
    rst_n = 1'b1;
    tick();
    run_op(ones, ones, 0, 1, ones, 1, 0, 1, 100);

    for (int i = 0; i < 3000; i++) begin
      logic [NW-1:0] a, b;
      logic op, cin;
      a   = rnd_opnd();
      b   = rnd_opnd();
      op  = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      model(a, b, op, cin, y_m, c_m, o_m);
      run_op(a, b, op, cin, y_m, c_m, o_m,
             $urandom_range(0, 2),
             $urandom_range(30, 100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
